// File: rtl/urv_mulh_sequencer_if.sv
// Handshake bundle between the X stage and the sequential multiply unit.
interface urv_mulh_sequencer_if;
  logic        x_kill_i;
  logic        d_start_i;
  logic [2:0]  d_fun_i;
  logic [31:0] d_rs1_i;
  logic [31:0] d_rs2_i;
  logic        x_stall_req_o;
  logic        x_done_o;
  logic [31:0] x_rd_o;

  modport master (
    output x_kill_i, d_start_i, d_fun_i, d_rs1_i, d_rs2_i,
    input  x_stall_req_o, x_done_o, x_rd_o
  );

  modport slave (
    input  x_kill_i, d_start_i, d_fun_i, d_rs1_i, d_rs2_i,
    output x_stall_req_o, x_done_o, x_rd_o
  );
endinterface

// File: rtl/urv_mulh_sequencer.sv
// Area-reduced uRV multiplier: one registered signed 18x18 multiplier time-shared over
// up to four partial products, summed in a 64-bit accumulator while X is stalled.

module urv_mult18x18 (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic signed [17:0] x_i,
  input  logic signed [17:0] y_i,
  output logic signed [35:0] xy_o
);
  always_ff @(posedge clk_i) begin
    if (rst_i)         xy_o <= '0;
    else if (!stall_i) xy_o <= x_i * y_i;
  end
endmodule

module urv_mulh_sequencer #(
  parameter bit g_skip_hh_for_mul = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  urv_mulh_sequencer_if.slave  bus
);
  localparam logic [2:0] FUNC_MUL    = 3'b000;
  localparam logic [2:0] FUNC_MULH   = 3'b001;
  localparam logic [2:0] FUNC_MULHSU = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Operand halves: low halves are 17-bit unsigned, high halves carry the sign.
  typedef struct packed {
    logic [17:0] xl;
    logic [17:0] xh;
    logic [17:0] yl;
    logic [17:0] yh;
  } ops_t;

  state_t      state_q, state_d;
  ops_t        ops_q, ops_d;
  logic [2:0]  fun_q;
  logic [1:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] rd_q;
  logic        vld_q;
  logic [1:0]  k_q;

  logic        accept, load_rd, last_pair;
  logic [1:0]  last_k;
  logic        sx, sy;
  logic [17:0] mx, my;
  logic [35:0] prod;
  logic [63:0] prod_ext, prod_sh, acc_sum;

  assign accept = (state_q == S_IDLE) && bus.d_start_i && !bus.x_kill_i;

  assign sx = bus.d_rs1_i[31] && (bus.d_fun_i == FUNC_MULH || bus.d_fun_i == FUNC_MULHSU);
  assign sy = bus.d_rs2_i[31] && (bus.d_fun_i == FUNC_MULH);

  always_comb begin
    ops_d.xl = {1'b0, bus.d_rs1_i[16:0]};
    ops_d.xh = {{3{sx}}, bus.d_rs1_i[31:17]};
    ops_d.yl = {1'b0, bus.d_rs2_i[16:0]};
    ops_d.yh = {{3{sy}}, bus.d_rs2_i[31:17]};
  end

  // xh*yh only lands at bit 34 and up, so a low-word MUL can stop after three pairs.
  assign last_k    = (g_skip_hh_for_mul && fun_q == FUNC_MUL) ? 2'd2 : 2'd3;
  assign last_pair = (cnt_q == last_k);

  always_comb begin
    mx = ops_q.xl;
    my = ops_q.yl;
    case (cnt_q)
      2'd0: begin mx = ops_q.xl; my = ops_q.yl; end
      2'd1: begin mx = ops_q.xl; my = ops_q.yh; end
      2'd2: begin mx = ops_q.xh; my = ops_q.yl; end
      default: begin mx = ops_q.xh; my = ops_q.yh; end
    endcase
  end

  urv_mult18x18 u_mult (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stall_i (1'b0),
    .x_i     (mx),
    .y_i     (my),
    .xy_o    (prod)
  );

  assign prod_ext = {{28{prod[35]}}, prod};

  always_comb begin
    prod_sh = prod_ext;
    case (k_q)
      2'd0:    prod_sh = prod_ext;
      2'd1,
      2'd2:    prod_sh = prod_ext << 17;
      default: prod_sh = prod_ext << 34;
    endcase
  end

  assign acc_sum = acc_q + (vld_q ? prod_sh : 64'd0);

  always_comb begin
    state_d           = state_q;
    load_rd           = 1'b0;
    bus.x_stall_req_o = 1'b0;
    bus.x_done_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.x_stall_req_o = accept;
        if (accept) state_d = S_RUN;
      end
      S_RUN: begin
        bus.x_stall_req_o = 1'b1;
        if (bus.x_kill_i)   state_d = S_IDLE;
        else if (last_pair) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        bus.x_stall_req_o = 1'b1;
        if (bus.x_kill_i) state_d = S_IDLE;
        else begin
          state_d = S_DONE;
          load_rd = 1'b1;
        end
      end
      default: begin
        // The instruction retires here; a start seen now belongs to it and is ignored.
        bus.x_done_o = !bus.x_kill_i;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ops_q   <= '0;
      fun_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rd_q    <= '0;
      vld_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= (state_q == S_RUN) && !bus.x_kill_i;
      k_q     <= cnt_q;
      if (accept) begin
        ops_q <= ops_d;
        fun_q <= bus.d_fun_i;
        cnt_q <= '0;
        acc_q <= '0;
      end else if (state_q == S_RUN) begin
        cnt_q <= cnt_q + 2'd1;
        acc_q <= acc_sum;
      end else if (state_q == S_DRAIN) begin
        acc_q <= acc_sum;
      end
      if (load_rd) rd_q <= (fun_q == FUNC_MUL) ? acc_sum[31:0] : acc_sum[63:32];
    end
  end

  assign bus.x_rd_o = rd_q;
endmodule

// File: tb/tb_urv_mulh_sequencer.sv
// Bench for urv_mulh_sequencer: two instances (hh skip on/off) against a cycle-level model.
module tb_urv_mulh_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  urv_mulh_sequencer_if if0 ();
  urv_mulh_sequencer_if if1 ();

  urv_mulh_sequencer #(.g_skip_hh_for_mul(1'b1)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  urv_mulh_sequencer #(.g_skip_hh_for_mul(1'b0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

  logic        st [2];
  logic        dn [2];
  logic [31:0] rdo[2];
  assign st[0] = if0.x_stall_req_o;  assign st[1] = if1.x_stall_req_o;
  assign dn[0] = if0.x_done_o;       assign dn[1] = if1.x_done_o;
  assign rdo[0] = if0.x_rd_o;        assign rdo[1] = if1.x_rd_o;

  int total = 0;
  int bad   = 0;

  // Reference product straight from 64-bit arithmetic.
  function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {{32{a[31] & (f == 3'd1 || f == 3'd2)}}, a};
    eb = {{32{b[31] & (f == 3'd1)}}, b};
    p  = ea * eb;
    return (f == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic int lat(input int i, input logic [2:0] f);
    return (f == 3'd0 && i == 0) ? 5 : 6;
  endfunction

  // Model: an accepted op is busy for lat-1 cycles, then shows done for one cycle.
  bit          armed = 1'b0;
  int          cyc = 0;
  bit          act[2];
  int          left[2];
  int          acc_cyc[2];
  logic [31:0] res[2];
  logic [31:0] mrd[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        armed  = 1'b1;
        act[i] = 1'b0;
        mrd[i] = 32'd0;
      end else if (act[i]) begin
        if (left[i] == 1 && !if0.x_kill_i) mrd[i] = res[i];
        if (if0.x_kill_i || left[i] == 0) act[i] = 1'b0;
        else left[i] = left[i] - 1;
      end else if (if0.d_start_i && !if0.x_kill_i) begin
        act[i]     = 1'b1;
        left[i]    = lat(i, if0.d_fun_i) - 1;
        res[i]     = ref_mul(if0.d_fun_i, if0.d_rs1_i, if0.d_rs2_i);
        acc_cyc[i] = cyc;
      end
    end
    cyc = cyc + 1;
  end

  bit          dir_on = 1'b0;
  logic [31:0] dir_rd;
  int          dir_lat[2];
  bit          pinned = 1'b0;

  task automatic chk(input string name, input int i, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, i, cyc, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (!pinned) begin
      pinned = 1'b1;
      chk("pin_mulhu", 0, ref_mul(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
      chk("pin_mulh_min", 0, ref_mul(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
      chk("pin_mulh_neg1", 0, ref_mul(3'd1, 32'hFFFFFFFF, 32'h00000001), 32'hFFFFFFFF);
      chk("pin_mulhsu", 0, ref_mul(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
      chk("pin_mul", 0, ref_mul(3'd0, 32'h00010003, 32'h00020005), 32'h000B000F);
    end
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk("stall", i, 32'(st[i]),
            32'(act[i] ? (left[i] > 0) : (if0.d_start_i && !if0.x_kill_i)));
        chk("done", i, 32'(dn[i]), 32'(act[i] && left[i] == 0 && !if0.x_kill_i));
        chk("rd", i, rdo[i], mrd[i]);
        if (dir_on && dn[i]) begin
          chk("dir_latency", i, 32'(cyc - acc_cyc[i]), 32'(dir_lat[i]));
          chk("dir_rd", i, rdo[i], dir_rd);
        end
      end
    end
  end

  task automatic drv(input logic s, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic k);
    if0.d_start_i = s; if0.d_fun_i = f; if0.d_rs1_i = a; if0.d_rs2_i = b; if0.x_kill_i = k;
    if1.d_start_i = s; if1.d_fun_i = f; if1.d_rs1_i = a; if1.d_rs2_i = b; if1.x_kill_i = k;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dir_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] rd, input int l0, input int l1);
    dir_rd = rd; dir_lat[0] = l0; dir_lat[1] = l1; dir_on = 1'b1;
    drv(1'b1, f, a, b, 1'b0);
    tick();
    drv(1'b0, 3'd0, 32'hDEADBEEF, 32'h12345678, 1'b0);
    repeat (9) tick();
    dir_on = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h00000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'h0001FFFF;
      5: return 32'h00020000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    dir_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6, 6);
    dir_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 6, 6);
    dir_op(3'd1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 6, 6);
    dir_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, 6);
    dir_op(3'd0, 32'h00010003, 32'h00020005, 32'h000B000F, 5, 6);

    // Kill at T+3, fresh MULHU at T+5.
    drv(1'b1, 3'd1, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    tick();
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) tick();
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    tick();
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    tick();
    dir_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6, 6);

    // Reset at T+2 of an operation.
    drv(1'b1, 3'd1, 32'h80000001, 32'h7FFFFFFF, 1'b0);
    tick();
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      drv($urandom_range(0, 2) == 0, 3'($urandom_range(0, 3)), pick(), pick(),
          $urandom_range(0, 15) == 0);
      tick();
    end
    rst = 1'b0;
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
